// File: rtl/debounce_pkg.sv
// Shared constants and counter sizing for the multi-channel button debouncer.
package debounce_pkg;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_CLK_DIV        = 1000000;
    localparam int DEF_STABLE_SAMPLES = 3;
    localparam int DEF_LONG_SAMPLES   = 100;
    localparam bit DEF_ACTIVE_LOW     = 1'b0;

    // Bits needed to hold every value 0..max_value (never fewer than one bit).
    function automatic int counter_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, stability qualification, level, edge
// pulses, toggle and long-press detection. Advances only on the shared tick.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int LONG_SAMPLES   = DEF_LONG_SAMPLES,
    parameter bit ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle,
    output logic long_press
);

    localparam int STAB_W = counter_width(STABLE_SAMPLES - 1);
    // The hold counter parks one above LONG_SAMPLES-1 once the pulse fired.
    localparam int HOLD_W = counter_width(LONG_SAMPLES);

    logic              sync_meta;
    logic              sync_out;
    logic              sample;
    logic              level_d;
    logic              level_up;
    logic [STAB_W-1:0] stab_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    assign sample   = sync_out ^ ACTIVE_LOW;
    assign level_up = level & ~level_d;

    // Two-flop synchronizer for the asynchronous button input.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= button;
            sync_out  <= sync_meta;
        end
    end

    // Accept a new level only after STABLE_SAMPLES consecutive differing ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt <= '0;
            level    <= 1'b0;
        end else if (tick) begin
            if (sample == level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == STAB_W'(STABLE_SAMPLES - 1)) begin
                level    <= sample;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
        end
    end

    // Registered edge detect: pulses and toggle follow a level change by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level_up;
            fall    <= ~level & level_d;
            if (level_up) begin
                toggle <= ~toggle;
            end
        end
    end

    // Count ticks of held-high level; fire long_press once, then saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!level) begin
                hold_cnt <= '0;
            end else if (tick) begin
                if (hold_cnt < HOLD_W'(LONG_SAMPLES - 1)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end else if (hold_cnt == HOLD_W'(LONG_SAMPLES - 1)) begin
                    long_press <= 1'b1;
                    hold_cnt   <= HOLD_W'(LONG_SAMPLES);
                end
            end
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent button debouncers sharing one sample-tick prescaler.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int LONG_SAMPLES   = DEF_LONG_SAMPLES,
    parameter bit ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] toggle,
    output logic [N_CH-1:0] long_press,
    output logic            any_event
);

    localparam int DIV_W = counter_width(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             tick_en;
    logic [1:0]       warm;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Ticks are ignored until the synchronizers hold real button data, so the
    // reset value of a synchronizer (inverted when ACTIVE_LOW) is never sampled.
    assign tick_en = tick & warm[1];

    // Shared prescaler: counts 0..CLK_DIV-1 and wraps on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Synchronizer fill tracker after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm <= 2'b00;
        end else begin
            warm <= {warm[0], 1'b1};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .LONG_SAMPLES  (LONG_SAMPLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_en),
            .button    (button[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .toggle    (toggle[i]),
            .long_press(long_press[i])
        );
    end

    assign any_event = |{rise, fall, long_press};

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench: an active-high and an ACTIVE_LOW build are driven with
// complementary buttons and both compared against one event-level model.
module tb_multi_debouncer;

    localparam int N   = 2;
    localparam int DIV = 4;
    localparam int S   = 3;
    localparam int L   = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] button;
    logic [N-1:0] button_n;

    logic [N-1:0] a_level, a_rise, a_fall, a_toggle, a_lp;
    logic         a_any;
    logic [N-1:0] b_level, b_rise, b_fall, b_toggle, b_lp;
    logic         b_any;

    assign button_n = ~button;

    always #5 clk = ~clk;

    multi_debouncer #(
        .N_CH(N), .CLK_DIV(DIV), .STABLE_SAMPLES(S), .LONG_SAMPLES(L), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .button(button),
        .level(a_level), .rise(a_rise), .fall(a_fall), .toggle(a_toggle),
        .long_press(a_lp), .any_event(a_any)
    );

    multi_debouncer #(
        .N_CH(N), .CLK_DIV(DIV), .STABLE_SAMPLES(S), .LONG_SAMPLES(L), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .button(button_n),
        .level(b_level), .rise(b_rise), .fall(b_fall), .toggle(b_toggle),
        .long_press(b_lp), .any_event(b_any)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample = button seen two clock edges earlier (0 right after reset);
    // tick every DIV-th edge after reset release.
    int           edge_cnt;
    int           hist1[N], hist2[N];
    int           lvl[N], run[N], held[N];
    bit           up_evt[N], dn_evt[N];
    logic [N-1:0] exp_rise, exp_fall, exp_lp, exp_tog;

    task automatic model_edge(input logic r, input logic [N-1:0] b);
        bit tick;
        if (r) begin
            edge_cnt = 0;
            for (int c = 0; c < N; c++) begin
                hist1[c] = 0; hist2[c] = 0; lvl[c] = 0; run[c] = 0; held[c] = 0;
                up_evt[c] = 0; dn_evt[c] = 0;
            end
            exp_rise = '0; exp_fall = '0; exp_lp = '0; exp_tog = '0;
            return;
        end
        edge_cnt++;
        tick     = (edge_cnt % DIV) == 0;
        exp_rise = '0; exp_fall = '0; exp_lp = '0;
        for (int c = 0; c < N; c++) begin
            exp_rise[c] = up_evt[c];
            exp_fall[c] = dn_evt[c];
            if (up_evt[c]) exp_tog[c] = ~exp_tog[c];
            up_evt[c] = 0;
            dn_evt[c] = 0;
            // held = number of ticks spent at level 1, capped at L
            if (lvl[c] == 0) held[c] = 0;
            else if (tick && held[c] < L) begin
                held[c]++;
                if (held[c] == L) exp_lp[c] = 1'b1;
            end
            if (tick) begin
                if (hist2[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == S) begin
                        lvl[c] = hist2[c];
                        run[c] = 0;
                        if (lvl[c] != 0) up_evt[c] = 1;
                        else             dn_evt[c] = 1;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            hist2[c] = hist1[c];
            hist1[c] = int'(b[c]);
        end
    endtask

    function automatic logic [N-1:0] exp_level();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = (lvl[c] != 0);
        return v;
    endfunction

    // ---------------- scenario bookkeeping ----------------
    int rise0_cnt, fall0_cnt, lp0_cnt, both_rise_cnt, any_cnt, rise1_cnt, al_rise_cnt;
    logic lvl1_seen;

    task automatic clear_win();
        rise0_cnt = 0; fall0_cnt = 0; lp0_cnt = 0; both_rise_cnt = 0;
        any_cnt = 0; rise1_cnt = 0; al_rise_cnt = 0; lvl1_seen = 1'b0;
    endtask

    task automatic compare_all();
        logic         exp_any;
        logic [N-1:0] lv;
        exp_any = |(exp_rise | exp_fall | exp_lp);
        lv      = exp_level();
        check("a.level",  32'(a_level),  32'(lv));
        check("a.rise",   32'(a_rise),   32'(exp_rise));
        check("a.fall",   32'(a_fall),   32'(exp_fall));
        check("a.toggle", 32'(a_toggle), 32'(exp_tog));
        check("a.long",   32'(a_lp),     32'(exp_lp));
        check("a.any",    32'(a_any),    32'(exp_any));
        check("b.level",  32'(b_level),  32'(lv));
        check("b.rise",   32'(b_rise),   32'(exp_rise));
        check("b.fall",   32'(b_fall),   32'(exp_fall));
        check("b.toggle", 32'(b_toggle), 32'(exp_tog));
        check("b.long",   32'(b_lp),     32'(exp_lp));
        check("b.any",    32'(b_any),    32'(exp_any));
    endtask

    // Drive inputs away from the edge, advance one clock, then compare.
    task automatic step(input logic r, input logic [N-1:0] b);
        rst    = r;
        button = b;
        model_edge(r, b);
        @(posedge clk);
        #1;
        compare_all();
        rise0_cnt     += int'(a_rise[0]);
        fall0_cnt     += int'(a_fall[0]);
        lp0_cnt       += int'(a_lp[0]);
        rise1_cnt     += int'(a_rise[1]);
        both_rise_cnt += int'(a_rise == 2'b11);
        any_cnt       += int'(a_any);
        al_rise_cnt   += int'(b_rise[0]);
        lvl1_seen     |= a_level[1];
    endtask

    task automatic hold(input logic [N-1:0] b, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, b);
    endtask

    initial begin
        int           dur[N];
        logic [N-1:0] rb;

        rst    = 1'b1;
        button = '0;
        clear_win();

        // Reset state, then idle: the ACTIVE_LOW build sees an idle-high pin.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
        hold(2'b00, 24);
        check("idle_level_al", 32'(b_level), 32'd0);
        check("idle_rise_al", 32'(al_rise_cnt), 32'd0);

        // Stable press held long enough for a long press, then release.
        clear_win();
        hold(2'b01, 60);
        check("press_rise_cnt", 32'(rise0_cnt), 32'd1);
        check("press_long_cnt", 32'(lp0_cnt), 32'd1);
        check("press_al_rise", 32'(al_rise_cnt), 32'd1);
        clear_win();
        hold(2'b00, 30);
        check("release_fall_cnt", 32'(fall0_cnt), 32'd1);

        // Glitch on channel 1: high for only two ticks.
        clear_win();
        hold(2'b10, 2 * DIV);
        hold(2'b00, 30);
        check("glitch_level", 32'(lvl1_seen), 32'd0);
        check("glitch_rise", 32'(rise1_cnt), 32'd0);

        // Both channels pressed in the same cycle.
        clear_win();
        hold(2'b11, 30);
        check("simul_rise11", 32'(both_rise_cnt), 32'd1);
        check("simul_any_cnt", 32'(any_cnt), 32'd1);
        hold(2'b00, 40);

        // Reset in the middle of qualification, then requalify from scratch.
        clear_win();
        hold(2'b01, 11);
        step(1'b1, 2'b01);
        check("midrst_level", 32'(a_level), 32'd0);
        hold(2'b01, 40);
        check("midrst_rise_cnt", 32'(rise0_cnt), 32'd1);
        hold(2'b00, 30);

        // Randomized buttons: mixes glitches, presses, long presses, rare resets.
        for (int c = 0; c < N; c++) dur[c] = 0;
        rb = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (dur[c] == 0) begin
                    rb[c]  = 1'($urandom_range(0, 1));
                    dur[c] = $urandom_range(1, 48);
                end
                dur[c]--;
            end
            step($urandom_range(0, 999) == 0, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
